// File: rtl/dsp_fft_bitrev_reorder.sv
// Ping-pong frame buffer that turns bit-reversed FFT output into a natural-order valid/ready stream.
// Optional macro DSP_BITREV_BYPASS_EN adds a bypass input for natural-order (plain FIFO) writes.
module dsp_fft_bitrev_reorder #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
`ifdef DSP_BITREV_BYPASS_EN
  input  logic              bypass,
`endif
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              dout_last,
  output logic              ovf
);

  localparam int N = 1 << LOG2N;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} rd_state_e;

  logic [DATA_W-1:0] mem_q [2*N];

  logic [LOG2N-1:0]  wr_cnt_q;
  logic              wr_bank_q;
  logic [1:0]        bank_full_q;
  logic [1:0]        bank_full_d;
  logic [LOG2N:0]    rd_cnt_q;
  logic              rd_bank_q;
  rd_state_e         state_q;
  logic [DATA_W-1:0] dout_q;
  logic              dout_vld_q;
  logic              dout_last_q;
  logic              ovf_q;

  logic              xfer_s;
  logic              release_s;
  logic              wr_ok_s;
  logic              wr_en_s;
  logic              wr_last_s;
  logic [LOG2N-1:0]  wr_idx_s;
  logic              rd_en_s;
  logic              rd_sel_s;
  logic [LOG2N-1:0]  rd_idx_s;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  // Write-side acceptance, write address and bank occupancy next state
  always_comb begin
`ifdef DSP_BITREV_BYPASS_EN
    if (bypass) wr_idx_s = wr_cnt_q;
    else        wr_idx_s = bitrev(wr_cnt_q);
`else
    wr_idx_s = bitrev(wr_cnt_q);
`endif
    xfer_s    = dout_vld_q & dout_rdy;
    release_s = xfer_s & dout_last_q;
    // A bank being released this cycle may already take the first word of the next frame
    wr_ok_s   = !bank_full_q[wr_bank_q] || (release_s && (rd_bank_q == wr_bank_q));
    wr_en_s   = din_vld & wr_ok_s;
    wr_last_s = wr_en_s && (wr_cnt_q == {LOG2N{1'b1}});
    bank_full_d = bank_full_q;
    if (release_s) bank_full_d[rd_bank_q] = 1'b0;
    else           bank_full_d[rd_bank_q] = bank_full_q[rd_bank_q];
    if (wr_last_s) bank_full_d[wr_bank_q] = 1'b1;
    else           bank_full_d[wr_bank_q] = bank_full_d[wr_bank_q];
  end

  // Read issue: fill the output register when it is empty or draining
  always_comb begin
    rd_en_s  = 1'b0;
    rd_sel_s = rd_bank_q;
    rd_idx_s = rd_cnt_q[LOG2N-1:0];
    case (state_q)
      IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          rd_en_s  = 1'b1;
          rd_idx_s = '0;
        end else begin
          rd_en_s  = 1'b0;
        end
      end
      STREAM: begin
        if (release_s) begin
          if (bank_full_q[~rd_bank_q]) begin
            rd_en_s  = 1'b1;
            rd_sel_s = ~rd_bank_q;
            rd_idx_s = '0;
          end else begin
            rd_en_s  = 1'b0;
          end
        end else if (!rd_cnt_q[LOG2N] && (!dout_vld_q || dout_rdy)) begin
          rd_en_s = 1'b1;
        end else begin
          rd_en_s = 1'b0;
        end
      end
      default: rd_en_s = 1'b0;
    endcase
  end

  // Frame storage write port
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_q[{wr_bank_q, wr_idx_s}] <= din;
  end

  // Write counters, read FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      state_q     <= IDLE;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_last_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      ovf_q       <= din_vld & ~wr_ok_s;
      bank_full_q <= bank_full_d;
      if (wr_en_s) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (wr_last_s) wr_bank_q <= ~wr_bank_q;
      end
      if (rd_en_s) begin
        dout_q      <= mem_q[{rd_sel_s, rd_idx_s}];
        dout_vld_q  <= 1'b1;
        dout_last_q <= (rd_idx_s == {LOG2N{1'b1}});
      end else if (xfer_s) begin
        dout_vld_q  <= 1'b0;
        dout_last_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (rd_en_s) begin
            state_q  <= STREAM;
            rd_cnt_q <= {{LOG2N{1'b0}}, 1'b1};
          end
        end
        STREAM: begin
          if (release_s) begin
            rd_bank_q <= ~rd_bank_q;
            if (rd_en_s) rd_cnt_q <= {{LOG2N{1'b0}}, 1'b1};
            else         state_q  <= IDLE;
          end else if (rd_en_s) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign dout_last = dout_last_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dsp_fft_bitrev_reorder.sv
// Directed bench for dsp_fft_bitrev_reorder with N=8: ordering, latency, back-to-back,
// stalls, overflow, mid-frame reset and (when DSP_BITREV_BYPASS_EN is defined) bypass.
module tb_dsp_fft_bitrev_reorder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] din = 16'd0;
  logic        din_vld = 1'b0;
  logic        dout_rdy = 1'b0;
  logic [15:0] dout;
  logic        dout_vld, dout_last, ovf;
`ifdef DSP_BITREV_BYPASS_EN
  logic        bypass = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ovf_cnt = 0;
  int rise_cyc = -1;
  logic [15:0] q_data[$];
  logic        q_last[$];
  int          q_cyc[$];
  logic        prev_stall = 1'b0;
  logic        prev_vld   = 1'b0;
  logic [15:0] prev_dout  = 16'd0;
  bit          rnd_en = 1'b0;

  dsp_fft_bitrev_reorder #(.DATA_W(16), .LOG2N(3)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
`ifdef DSP_BITREV_BYPASS_EN
    .bypass(bypass),
`endif
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .dout_last(dout_last), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: record transfers, ovf pulses and stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_vld   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_dout", dout, prev_dout);
        check("hold_vld", dout_vld, 1);
      end
      if (dout_vld && !prev_vld) rise_cyc = cyc;
      if (dout_vld && dout_rdy) begin
        q_data.push_back(dout);
        q_last.push_back(dout_last);
        q_cyc.push_back(cyc);
      end
      if (ovf) ovf_cnt++;
      prev_stall = dout_vld && !dout_rdy;
      prev_dout  = dout;
      prev_vld   = dout_vld;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) dout_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    din_vld = 1'b0;
    dout_rdy = 1'b0;
    rnd_en  = 1'b0;
    #1;
    check("rst_dout", dout, 0);
    check("rst_vld", dout_vld, 0);
    check("rst_last", dout_last, 0);
    check("rst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    ovf_cnt = 0;
  endtask

  task automatic push(input logic [15:0] d, output int wcyc);
    din     = d;
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    wcyc    = cyc;
  endtask

  task automatic push_range(input int first, input int n);
    int w;
    for (int i = 0; i < n; i++) push(16'(first + i), w);
  endtask

  task automatic wait_n(input int n, input int budget);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (q_data.size() < n) check("timeout", q_data.size(), n);
  endtask

  task automatic check_frame(input string tag, input int qi, input int base);
    int perm[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int i = 0; i < 8; i++) begin
      if (qi + i < q_data.size()) begin
        check({tag, "_data"}, q_data[qi+i], base + perm[i]);
        check({tag, "_last"}, q_last[qi+i], (i == 7) ? 1 : 0);
      end else begin
        check({tag, "_missing"}, q_data.size(), qi + i + 1);
      end
    end
  endtask

  initial begin
    int w;
    #2;
    // 1: single frame, latency
    do_reset();
    dout_rdy = 1'b1;
    for (int i = 0; i < 8; i++) push(16'(i), w);
    wait_n(8, 50);
    check_frame("t1", 0, 0);
    check("t1_latency", rise_cyc, w + 1);

    // 2: three frames back-to-back, no gaps, no overflow
    do_reset();
    dout_rdy = 1'b1;
    push_range(0, 24);
    wait_n(24, 60);
    for (int f = 0; f < 3; f++) check_frame("t2", 8 * f, 8 * f);
    for (int i = 1; i < 24; i++)
      if (i < q_cyc.size()) check("t2_gap", q_cyc[i] - q_cyc[0], i);
    check("t2_ovf", ovf_cnt, 0);

    // 3: random downstream ready
    do_reset();
    rnd_en = 1'b1;
    push_range(0, 16);
    wait_n(16, 400);
    rnd_en = 1'b0;
    dout_rdy = 1'b1;
    check_frame("t3f0", 0, 0);
    check_frame("t3f1", 8, 8);

    // 4: output blocked, third frame dropped
    do_reset();
    push_range(0, 24);
    repeat (3) @(posedge clk);
    #1;
    check("t4_ovf_cnt", ovf_cnt, 8);
    check("t4_no_xfer", q_data.size(), 0);
    check("t4_held_vld", dout_vld, 1);
    dout_rdy = 1'b1;
    wait_n(16, 100);
    repeat (20) @(posedge clk);
    #1;
    check("t4_count", q_data.size(), 16);
    check_frame("t4f0", 0, 0);
    check_frame("t4f1", 8, 8);

    // 5: reset with a stalled frame and a partial frame in flight
    do_reset();
    push_range(50, 8);
    push_range(60, 5);
    @(posedge clk);
    #1;
    check("t5_pre_dout", dout, 50);
    do_reset();
    dout_rdy = 1'b1;
    push_range(100, 8);
    wait_n(8, 50);
    repeat (20) @(posedge clk);
    #1;
    check("t5_count", q_data.size(), 8);
    check_frame("t5", 0, 100);

`ifdef DSP_BITREV_BYPASS_EN
    // 6: bypass gives natural-order FIFO behaviour
    do_reset();
    bypass = 1'b1;
    dout_rdy = 1'b1;
    push_range(0, 8);
    wait_n(8, 50);
    for (int i = 0; i < 8; i++)
      if (i < q_data.size()) check("t6_data", q_data[i], i);
    bypass = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
